alu_mc: RTL and testbench
=========================

// Module: alu_mc
//
// PURPOSE
// Multi-cycle, parametrised successor to the combinational ALU. It accepts one operation per start pulse and
// executes single-cycle ops in 1 clock. MUL, DIV and MOD run iteratively, one bit per clock, instead of using
// combinational * / %. It adds variable-distance rotates, zero and divide-by-zero flags, and a start/busy/done
// handshake so the control unit can stall the datapath.
//
// PARAMETERS
// tamOp   32                 operand/result width in bits (>=8, power of 2)
// SHW     $clog2(tamOp)      localparam: shift/rotate amount width
//
// PORTS
// clk      in   1      rising-edge clock
// rst_n    in   1      asynchronous active-low reset
// start    in   1      launch operation; sampled only when busy=0
// a        in   tamOp  operand A
// b        in   tamOp  operand B
// shift    in   SHW    shift/rotate distance
// funct    in   6      operation code (encodings below)
// busy     out  1      operation in flight; start is ignored
// done     out  1      1-cycle pulse; rs/flags valid from this cycle
// rs       out  tamOp  result, held until next done
// branch   out  1      branch condition, held until next done
// zero     out  1      rs==0, held until next done
// dbz      out  1      last DIV/MOD had b==0, held until next done
//
// BEHAVIOUR
// - Reset (async, any state): FSM->IDLE; busy, done, rs, branch, zero, dbz = 0. An in-flight op is aborted; no done.
// - Codes: 00 sll, 01 srl, 02 sra (signed), 03 rotl by shift, 04 rotr by shift, 05 add, 06 sub, 07 mul,
//   08 div, 09 inc a, 0A dec a, 0B mod, 0C and, 0D or, 0E not a, 0F xor, 10 move a, 11 slt (signed),
//   12 sgt (signed), 13 seq (rs=a==b, branch=rs[0]), 14 bne (branch=a!=b, rs=0).
//   Any other code: rs=0, branch=0.
// - Rotate distance is taken mod tamOp. shift=0 returns a unchanged.
// - Add/sub/inc/dec wrap modulo 2^tamOp. There is no overflow output.
// - On IDLE & start, a, b, shift and funct are latched. Later input changes have no effect.
// - FSM: IDLE -> (single-cycle op) DONE; IDLE -> MUL | DIV; MUL/DIV -> DONE after tamOp iterations;
//   DONE -> IDLE.
// - Single-cycle ops: start at cycle N -> done=1 at N+1. busy=0 throughout.
// - MUL: shift-add over unsigned operands; rs = low tamOp bits of a*b. busy=1 for cycles N+1..N+tamOp.
//   done at N+tamOp+1.
// - DIV/MOD: unsigned restoring divider; DIV rs=a/b, MOD rs=a%b. Timing is the same as MUL.
// - b==0 for DIV/MOD: no iteration. done at N+1 with dbz=1. DIV gives rs={tamOp{1'b1}}, MOD gives rs=a.
// - dbz=0 for every other completion.
// - zero = (rs==0) is registered with rs. branch=0 for all codes except 13 and 14.
// - done high -> busy low in the same cycle. start in the done cycle is accepted (back-to-back issue).
// - start while busy=1 is ignored, with no side effects.
//
// STRUCTURE
// - Shared package alu_pkg: funct localparams (ALU_SLL..ALU_BNE), FSM state encoding, and an is_multicycle()
//   function.
// - One sub-module, alu_iter: the shared iterative mul/div datapath (accumulator, partial remainder, bit counter).
//   It takes start/op, drives fin, and ties to alu_mc via that start/fin handshake.
// - alu_mc holds the FSM, the single-cycle ops and the output registers.
//
// TESTING
// - Reset: rst_n=0 mid-MUL (cycle 5) -> all outputs 0 immediately. After rst_n=1, no done pulse, and the next op
//   works.
// - Single-cycle: funct=05, a=7, b=5 -> done at N+1, rs=12, zero=0. funct=13, a=b=9 -> rs=1, branch=1.
//   funct=04, a=1, shift=1 -> rs=0x80000000.
// - MUL, tamOp=32: a=0x10000, b=0x10001 -> done at N+33, rs=0x00010000. busy=1 for exactly 32 cycles.
// - DIV/MOD: a=100, b=7 -> DIV rs=14, MOD rs=2, done at N+33, dbz=0.
//   b=0 -> done at N+1, dbz=1, DIV rs=0xFFFFFFFF, MOD rs=100.
// - Handshake: pulse start while busy -> ignored; result matches the first op.
//   start in the done cycle with funct=09, a=3 -> accepted, rs=4 one cycle later.
// - Width sweep at tamOp=8 and 64: random ops vs reference model. MUL/DIV latency = tamOp+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM encoding and
// the helper that decides whether an operation runs on the iterative datapath.
package alu_pkg;

  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_SRL  = 6'h01;
  localparam logic [5:0] ALU_SRA  = 6'h02;
  localparam logic [5:0] ALU_ROTL = 6'h03;
  localparam logic [5:0] ALU_ROTR = 6'h04;
  localparam logic [5:0] ALU_ADD  = 6'h05;
  localparam logic [5:0] ALU_SUB  = 6'h06;
  localparam logic [5:0] ALU_MUL  = 6'h07;
  localparam logic [5:0] ALU_DIV  = 6'h08;
  localparam logic [5:0] ALU_INC  = 6'h09;
  localparam logic [5:0] ALU_DEC  = 6'h0A;
  localparam logic [5:0] ALU_MOD  = 6'h0B;
  localparam logic [5:0] ALU_AND  = 6'h0C;
  localparam logic [5:0] ALU_OR   = 6'h0D;
  localparam logic [5:0] ALU_NOT  = 6'h0E;
  localparam logic [5:0] ALU_XOR  = 6'h0F;
  localparam logic [5:0] ALU_MOV  = 6'h10;
  localparam logic [5:0] ALU_SLT  = 6'h11;
  localparam logic [5:0] ALU_SGT  = 6'h12;
  localparam logic [5:0] ALU_SEQ  = 6'h13;
  localparam logic [5:0] ALU_BNE  = 6'h14;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} alu_state_e;
  typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_MOD} iter_op_e;

  function automatic logic is_multicycle(input logic [5:0] f);
    return (f == ALU_MUL) || (f == ALU_DIV) || (f == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Shared iterative datapath: shift-add multiplier and restoring divider, one bit
// per clock. fin is high in the last iteration cycle with result already final.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  iter_op_e     op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         fin,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  iter_op_e      op_q, op_d;
  // acc: product accumulator (MUL) or partial remainder (DIV/MOD)
  // opa: shifting multiplicand (MUL) or dividend/quotient register (DIV/MOD)
  // opb: shifting multiplier (MUL) or fixed divisor (DIV/MOD)
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W:0]    rem_shift;
  logic [W:0]    rem_diff;

  always_comb begin
    run_d     = run_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_shift = {acc_q, opa_q[W-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    fin       = run_q && (cnt_q == CW'(W - 1));
    if (start && !run_q) begin
      run_d = 1'b1;
      cnt_d = '0;
      op_d  = op;
      acc_d = '0;
      opa_d = a;
      opb_d = b;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (fin) run_d = 1'b0;
      if (op_q == IT_MUL) begin
        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else if (!rem_diff[W]) begin
        acc_d = rem_diff[W-1:0];
        opa_d = {opa_q[W-2:0], 1'b1};
      end else begin
        acc_d = rem_shift[W-1:0];
        opa_d = {opa_q[W-2:0], 1'b0};
      end
    end
    result = (op_q == IT_DIV) ? opa_d : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= IT_MUL;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete in one clock, MUL/DIV/MOD use the
// shared iterative datapath. start is honoured whenever busy is low.
module alu_mc
  import alu_pkg::*;
#(
  parameter int tamOp = 32,
  localparam int SHW = $clog2(tamOp)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [tamOp-1:0] a,
  input  logic [tamOp-1:0] b,
  input  logic [SHW-1:0]   shift,
  input  logic [5:0]       funct,
  output logic             busy,
  output logic             done,
  output logic [tamOp-1:0] rs,
  output logic             branch,
  output logic             zero,
  output logic             dbz
);

  alu_state_e         state_q, state_d;
  logic [tamOp-1:0]   rs_q, rs_d;
  logic               branch_q, branch_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;
  logic               load;
  logic               accept;
  logic               div0;
  logic               it_start;
  logic               it_fin;
  iter_op_e           it_op;
  logic [tamOp-1:0]   it_result;
  logic [tamOp-1:0]   sc_rs;
  logic               sc_br;
  logic [2*tamOp-1:0] rotl_w;
  logic [2*tamOp-1:0] rotr_w;

  assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done     = (state_q == ST_DONE);
  assign accept   = start && !busy;
  assign div0     = ((funct == ALU_DIV) || (funct == ALU_MOD)) && (b == '0);
  assign it_start = accept && is_multicycle(funct) && !div0;
  assign it_op    = (funct == ALU_MUL) ? IT_MUL : (funct == ALU_DIV) ? IT_DIV : IT_MOD;

  // Rotates are taken from the doubled operand so shift=0 naturally returns a.
  always_comb begin
    rotl_w = {a, a} << shift;
    rotr_w = {a, a} >> shift;
    sc_rs  = '0;
    sc_br  = 1'b0;
    case (funct)
      ALU_SLL:  sc_rs = a << shift;
      ALU_SRL:  sc_rs = a >> shift;
      ALU_SRA:  sc_rs = $signed(a) >>> shift;
      ALU_ROTL: sc_rs = rotl_w[2*tamOp-1:tamOp];
      ALU_ROTR: sc_rs = rotr_w[tamOp-1:0];
      ALU_ADD:  sc_rs = a + b;
      ALU_SUB:  sc_rs = a - b;
      ALU_INC:  sc_rs = a + tamOp'(1);
      ALU_DEC:  sc_rs = a - tamOp'(1);
      ALU_AND:  sc_rs = a & b;
      ALU_OR:   sc_rs = a | b;
      ALU_NOT:  sc_rs = ~a;
      ALU_XOR:  sc_rs = a ^ b;
      ALU_MOV:  sc_rs = a;
      ALU_SLT:  sc_rs = {{(tamOp-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SGT:  sc_rs = {{(tamOp-1){1'b0}}, $signed(a) > $signed(b)};
      ALU_SEQ: begin
        sc_rs = {{(tamOp-1){1'b0}}, a == b};
        sc_br = (a == b);
      end
      ALU_BNE:  sc_br = (a != b);
      default: begin
        sc_rs = '0;
        sc_br = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    branch_d = branch_q;
    dbz_d    = dbz_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (it_start) begin
            state_d = (funct == ALU_MUL) ? ST_MUL : ST_DIV;
          end else begin
            state_d  = ST_DONE;
            load     = 1'b1;
            rs_d     = div0 ? ((funct == ALU_DIV) ? '1 : a) : sc_rs;
            branch_d = div0 ? 1'b0 : sc_br;
            dbz_d    = div0;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_fin) begin
          state_d  = ST_DONE;
          load     = 1'b1;
          rs_d     = it_result;
          branch_d = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = load ? (rs_d == '0) : zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rs_q     <= '0;
      branch_q <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      branch_q <= branch_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign rs     = rs_q;
  assign branch = branch_q;
  assign zero   = zero_q;
  assign dbz    = dbz_q;

  alu_iter #(.W(tamOp)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (it_start),
    .op     (it_op),
    .a      (a),
    .b      (b),
    .fin    (it_fin),
    .result (it_result)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: 32-bit vector table with scoreboard, reset/handshake
// sequences, and random sweeps at 8 and 64 bits against a reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int SHW = $clog2(W);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start;
  logic [W-1:0]   a, b, rs;
  logic [SHW-1:0] shift;
  logic [5:0]     funct;
  logic           busy, done, branch, zero, dbz;

  int n_checks = 0;
  int n_errors = 0;
  int sweep_go = 0;
  logic [1:0] sweep_fin = 2'b00;

  logic [W+2:0] exp_q[$];

  typedef struct {
    logic [5:0]     f;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SHW-1:0] sh;
    logic [W-1:0]   rs;
    logic           br;
    logic           dz;
    int             lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_mc #(.tamOp(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .shift(shift),
    .funct(funct), .busy(busy), .done(done), .rs(rs), .branch(branch),
    .zero(zero), .dbz(dbz)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every done pulse of the 32-bit DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("scoreboard", {dbz, branch, zero, rs}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [SHW-1:0] sh, input int exp_lat, input logic [W+2:0] exp,
                       input bit poke);
    int lat;
    int busy_cnt;
    @(negedge clk);
    funct = f; a = va; b = vb; shift = sh; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; shift = SHW'($urandom); funct = 6'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < W + 10) begin
      if (busy) busy_cnt++;
      if (poke && lat == 3) begin
        start = 1'b1; funct = ALU_ADD; a = 1; b = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_at_done", busy, 0);
    check("busy_cycles", busy_cnt, exp_lat - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; a = '0; b = '0; shift = '0; funct = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, rs, branch, zero, dbz}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{ALU_ADD,  32'd7,          32'd5,          5'd0,  32'd12,         1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SEQ,  32'd9,          32'd9,          5'd0,  32'd1,          1'b1, 1'b0, 1});
    vecs.push_back('{ALU_ROTR, 32'd1,          32'd0,          5'd1,  32'h8000_0000,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_MUL,  32'h0001_0000,  32'h0001_0001,  5'd0,  32'h0001_0000,  1'b0, 1'b0, 33});
    vecs.push_back('{ALU_DIV,  32'd100,        32'd7,          5'd0,  32'd14,         1'b0, 1'b0, 33});
    vecs.push_back('{ALU_MOD,  32'd100,        32'd7,          5'd0,  32'd2,          1'b0, 1'b0, 33});
    vecs.push_back('{ALU_DIV,  32'd100,        32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b1, 1});
    vecs.push_back('{ALU_MOD,  32'd100,        32'd0,          5'd0,  32'd100,        1'b0, 1'b1, 1});
    vecs.push_back('{ALU_SLL,  32'd1,          32'd0,          5'd31, 32'h8000_0000,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SRL,  32'h8000_0000,  32'd0,          5'd4,  32'h0800_0000,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SRA,  32'h8000_0000,  32'd0,          5'd4,  32'hF800_0000,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_ROTL, 32'h8000_0001,  32'd0,          5'd4,  32'h0000_0018,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_ROTL, 32'h1234_5678,  32'd0,          5'd0,  32'h1234_5678,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SUB,  32'd3,          32'd5,          5'd0,  32'hFFFF_FFFE,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_ADD,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_INC,  32'hFFFF_FFFF,  32'd9,          5'd0,  32'd0,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_DEC,  32'd0,          32'd9,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_AND,  32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_F000,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_OR,   32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_FFF0,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_NOT,  32'd0,          32'd5,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_XOR,  32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_0FF0,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_MOV,  32'hDEAD_BEEF,  32'd5,          5'd0,  32'hDEAD_BEEF,  1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SGT,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_BNE,  32'd3,          32'd4,          5'd0,  32'd0,          1'b1, 1'b0, 1});
    vecs.push_back('{ALU_BNE,  32'd5,          32'd5,          5'd0,  32'd0,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_SEQ,  32'd1,          32'd2,          5'd0,  32'd0,          1'b0, 1'b0, 1});
    vecs.push_back('{6'h3F,    32'd1,          32'd2,          5'd0,  32'd0,          1'b0, 1'b0, 1});
    vecs.push_back('{ALU_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'd1,          1'b0, 1'b0, 33});
    vecs.push_back('{ALU_MUL,  32'h1234_5678,  32'd0,          5'd0,  32'd0,          1'b0, 1'b0, 33});
    vecs.push_back('{ALU_MOD,  32'hFFFF_FFFF,  32'h10,         5'd0,  32'h0000_000F,  1'b0, 1'b0, 33});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFFF,  32'h10,         5'd0,  32'h0FFF_FFFF,  1'b0, 1'b0, 33});

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].lat,
            {vecs[i].dz, vecs[i].br, vecs[i].rs == '0, vecs[i].rs}, 1'b0);
    end

    // start while busy is ignored; the following INC lands in the done cycle
    issue(ALU_MUL, 32'd6, 32'd7, '0, 33, {3'b000, 32'd42}, 1'b1);
    issue(ALU_INC, 32'd3, 32'd0, '0, 1, {3'b000, 32'd4}, 1'b0);
    issue(ALU_SEQ, 32'd8, 32'd8, '0, 1, {3'b010, 32'd1}, 1'b0);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    funct = ALU_MUL; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, rs, branch, zero, dbz}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_reset", done, 0);
    issue(ALU_ADD, 32'd20, 32'd22, '0, 1, {3'b000, 32'd42}, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    sweep_go = 1;
    wait (sweep_fin[0]);
    sweep_go = 2;
    wait (sweep_fin[1]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SW  = (gi == 0) ? 8 : 64;
    localparam int SSH = $clog2(SW);

    logic           s_start;
    logic [SW-1:0]  s_a, s_b, s_rs;
    logic [SSH-1:0] s_sh;
    logic [5:0]     s_f;
    logic           s_busy, s_done, s_br, s_zero, s_dbz;

    alu_mc #(.tamOp(SW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .shift(s_sh),
      .funct(s_f), .busy(s_busy), .done(s_done), .rs(s_rs), .branch(s_br),
      .zero(s_zero), .dbz(s_dbz)
    );

    function automatic void ref_op(input logic [5:0] f, input logic [SW-1:0] x,
                                   input logic [SW-1:0] y, input int s,
                                   output logic [SW-1:0] r, output logic br, output logic dz);
      r = '0; br = 1'b0; dz = 1'b0;
      case (f)
        6'h00: r = x << s;
        6'h01: r = x >> s;
        6'h02: r = $unsigned($signed(x) >>> s);
        6'h03: r = (s == 0) ? x : ((x << s) | (x >> (SW - s)));
        6'h04: r = (s == 0) ? x : ((x >> s) | (x << (SW - s)));
        6'h05: r = x + y;
        6'h06: r = x - y;
        6'h07: r = x * y;
        6'h08: if (y == '0) begin r = '1; dz = 1'b1; end else r = x / y;
        6'h09: r = x + SW'(1);
        6'h0A: r = x - SW'(1);
        6'h0B: if (y == '0) begin r = x; dz = 1'b1; end else r = x % y;
        6'h0C: r = x & y;
        6'h0D: r = x | y;
        6'h0E: r = ~x;
        6'h0F: r = x ^ y;
        6'h10: r = x;
        6'h11: r = {{(SW-1){1'b0}}, $signed(x) < $signed(y)};
        6'h12: r = {{(SW-1){1'b0}}, $signed(x) > $signed(y)};
        6'h13: begin r = {{(SW-1){1'b0}}, x == y}; br = (x == y); end
        6'h14: br = (x != y);
        default: r = '0;
      endcase
    endfunction

    initial begin
      logic [5:0]    f;
      logic [SW-1:0] x, y, r;
      logic          br, dz;
      int            s, lat, exp_lat;
      s_start = 1'b0; s_a = '0; s_b = '0; s_sh = '0; s_f = '0;
      wait (sweep_go == gi + 1);
      for (int i = 0; i < 24; i++) begin
        if (i < 6) f = (i % 3 == 0) ? ALU_MUL : (i % 3 == 1) ? ALU_DIV : ALU_MOD;
        else f = 6'($urandom_range(0, 21));
        if (f == 6'd21) f = 6'h3F;
        x = SW'({$urandom, $urandom});
        y = (i % 7 == 4) ? '0 : SW'({$urandom, $urandom});
        s = $urandom_range(0, SW - 1);
        ref_op(f, x, y, s, r, br, dz);
        exp_lat = ((f == ALU_MUL) || (((f == ALU_DIV) || (f == ALU_MOD)) && y != '0)) ? SW + 1 : 1;
        @(negedge clk);
        s_f = f; s_a = x; s_b = y; s_sh = SSH'(s); s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_a = SW'({$urandom, $urandom});
        lat = 1;
        while (!s_done && lat < SW + 10) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("sweep%0d_f%0h", SW, f), {s_dbz, s_br, s_zero, s_rs}, {dz, br, r == '0, r});
        check($sformatf("sweep%0d_latency", SW), lat, exp_lat);
      end
      sweep_fin[gi] = 1'b1;
    end
  end

endmodule
